// File: rtl/bcd_digit_scanner.sv
// bcd_digit_scanner: snapshots NUM_FIELDS binary fields, converts each to two
// BCD digits with a bit-serial double-dabble engine, double-buffers the digits
// and time-multiplexes them (MSD first) onto a single BCD/dp output with a
// one-hot digit select. Display updates only on frame boundaries (no tearing).
module bcd_digit_scanner #(
  parameter int NUM_FIELDS  = 3,
  parameter int FIELD_WIDTH = 7,
  parameter int SCAN_DIV    = 16
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic                              i_en,
  input  logic                              i_load,
  input  logic [NUM_FIELDS*FIELD_WIDTH-1:0] i_fields,
  input  logic [2*NUM_FIELDS-1:0]           i_dp,
  input  logic                              i_blank_lz,
  output logic                              o_busy,
  output logic [3:0]                        o_bcd,
  output logic                              o_dp,
  output logic                              o_blank,
  output logic [2*NUM_FIELDS-1:0]           o_digit_sel
);

  localparam int D          = 2 * NUM_FIELDS;
  localparam int TOTAL_BITS = NUM_FIELDS * FIELD_WIDTH;
  localparam int FLD_W      = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int BIT_W      = $clog2(FIELD_WIDTH);
  localparam int DW_W       = $clog2(SCAN_DIV);
  localparam int IDX_W      = $clog2(D);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [TOTAL_BITS-1:0]   r_snap;
  logic [FLD_W-1:0]        r_fld;
  logic [BIT_W-1:0]        r_bit;
  logic [7:0]              r_acc;
  logic [FIELD_WIDTH-1:0]  r_bin;
  logic [3:0]              r_pend [D];
  logic [3:0]              r_disp [D];
  logic [DW_W-1:0]         r_dwell;
  logic [IDX_W-1:0]        r_idx;

  logic                    w_in_bit;
  logic [7:0]              w_adj;
  logic [7:0]              w_acc_nxt;
  logic [FIELD_WIDTH-1:0]  w_bin_nxt;
  logic                    w_ovf;
  logic [3:0]              w_tens;
  logic [3:0]              w_ones;
  logic                    w_last_bit;
  logic                    w_field_done;
  logic                    w_tick;
  logic                    w_boundary;
  logic [3:0]              w_cur;

  // Double-dabble step: adjust nibbles >=5, then shift in the next field bit.
  // The snapshot is shifted left as a whole, so its MSB walks through the
  // fields highest-first, MSB-first. A plain binary copy of the field is built
  // alongside so overflow (>=100) can be detected on the last bit.
  always_comb begin
    w_in_bit     = r_snap[TOTAL_BITS-1];
    w_adj[7:4]   = (r_acc[7:4] >= 4'd5) ? r_acc[7:4] + 4'd3 : r_acc[7:4];
    w_adj[3:0]   = (r_acc[3:0] >= 4'd5) ? r_acc[3:0] + 4'd3 : r_acc[3:0];
    w_acc_nxt    = 8'({w_adj, w_in_bit});
    w_bin_nxt    = FIELD_WIDTH'({r_bin, w_in_bit});
    w_ovf        = 8'(w_bin_nxt) >= 8'd100;
    w_tens       = w_ovf ? 4'hF : w_acc_nxt[7:4];
    w_ones       = w_ovf ? 4'hF : w_acc_nxt[3:0];
    w_last_bit   = (r_bit == BIT_W'(FIELD_WIDTH - 1));
    w_field_done = (r_state == S_SHIFT) && w_last_bit;
  end

  // Scan timing: terminal dwell count and frame boundary (frozen when disabled).
  always_comb begin
    w_tick     = i_en && (r_dwell == DW_W'(SCAN_DIV - 1));
    w_boundary = w_tick && (r_idx == IDX_W'(D - 1));
  end

  // Conversion FSM state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Conversion FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_load) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_field_done && (r_fld == '0)) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_boundary) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Conversion datapath: snapshot, bit-serial conversion, pending/display buffers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_snap <= '0;
      r_fld  <= '0;
      r_bit  <= '0;
      r_acc  <= '0;
      r_bin  <= '0;
      for (int unsigned k = 0; k < D; k++) begin
        r_pend[k] <= '0;
        r_disp[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_load) begin
            r_snap <= i_fields;
            r_fld  <= FLD_W'(NUM_FIELDS - 1);
            r_bit  <= '0;
            r_acc  <= '0;
            r_bin  <= '0;
          end
        end
        S_SHIFT: begin
          r_snap <= r_snap << 1;
          if (w_last_bit) begin
            r_bit <= '0;
            r_acc <= '0;
            r_bin <= '0;
            r_fld <= r_fld - FLD_W'(1);
            // Field f owns digit indices 2*(N-1-f) (tens) and +1 (ones).
            for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
              if (r_fld == FLD_W'(f)) begin
                r_pend[2*(NUM_FIELDS-1-f)]   <= w_tens;
                r_pend[2*(NUM_FIELDS-1-f)+1] <= w_ones;
              end
            end
          end else begin
            r_bit <= r_bit + BIT_W'(1);
            r_acc <= w_acc_nxt;
            r_bin <= w_bin_nxt;
          end
        end
        S_WAIT: begin
          if (w_boundary) begin
            for (int unsigned k = 0; k < D; k++) r_disp[k] <= r_pend[k];
          end
        end
        default: ;
      endcase
    end
  end

  // Scanner: dwell counter and digit index, both held while disabled.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dwell <= '0;
      r_idx   <= '0;
    end else if (i_en) begin
      if (w_tick) begin
        r_dwell <= '0;
        r_idx   <= (r_idx == IDX_W'(D - 1)) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_dwell <= r_dwell + DW_W'(1);
      end
    end
  end

  // Display outputs, combinational from the registered index and display buffer.
  always_comb begin
    w_cur       = r_disp[r_idx];
    o_busy      = (r_state != S_IDLE);
    o_bcd       = w_cur;
    o_dp        = i_dp[IDX_W'(D - 1) - r_idx];
    o_digit_sel = i_en ? (D'(1) << r_idx) : '0;
    o_blank     = !i_en || (i_blank_lz && (r_idx == '0) && (w_cur == 4'd0));
  end

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Testbench for bcd_digit_scanner (N=3, W=7, SCAN_DIV=4): timeline sequences
// for reset, mid-frame load, ignored load, reset abort, boundary-aligned SHIFT
// end and enable freeze, then a table of directed conversion vectors.
module tb_bcd_digit_scanner;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_en;
  logic        i_load;
  logic [20:0] i_fields;
  logic [5:0]  i_dp;
  logic        i_blank_lz;
  logic        o_busy;
  logic [3:0]  o_bcd;
  logic        o_dp;
  logic        o_blank;
  logic [5:0]  o_digit_sel;

  int n_total = 0;
  int n_pass  = 0;
  int n;   // cycles since last reset release
  int sc;  // enabled cycles since last reset release (scan position)

  bcd_digit_scanner #(
    .NUM_FIELDS (3),
    .FIELD_WIDTH(7),
    .SCAN_DIV   (4)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (i_reset_n),
    .i_en       (i_en),
    .i_load     (i_load),
    .i_fields   (i_fields),
    .i_dp       (i_dp),
    .i_blank_lz (i_blank_lz),
    .o_busy     (o_busy),
    .o_bcd      (o_bcd),
    .o_dp       (o_dp),
    .o_blank    (o_blank),
    .o_digit_sel(o_digit_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  typedef struct {
    logic [6:0]  h, m, s;
    logic        blz;
    logic [5:0]  dp;
    logic [23:0] exp;     // expected digits, index 0 in the top nibble
    logic        blank0;  // expected o_blank on digit index 0
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (n=%0d)", nm, act, exp, n);
  endtask

  task automatic tick();
    if (i_en) sc++;
    @(posedge clk);
    #1;
    n++;
  endtask

  function automatic logic [3:0] dig(input logic [23:0] v, input int k);
    return v[(5-k)*4 +: 4];
  endfunction

  function automatic logic [20:0] pack(input logic [6:0] h, input logic [6:0] m, input logic [6:0] s);
    return {h, m, s};
  endfunction

  // Per-cycle check of the scan position and displayed digit.
  task automatic scan_chk(input logic exp_busy, input logic [23:0] digits);
    int idx;
    idx = (sc / 4) % 6;
    chk("sel",   o_digit_sel, 6'(1) << idx);
    chk("bcd",   o_bcd, dig(digits, idx));
    chk("busy",  o_busy, exp_busy);
    chk("dp",    o_dp, i_dp[5-idx]);
    chk("blank", o_blank, 1'b0);
  endtask

  localparam logic [23:0] A = 24'h123456;
  localparam logic [23:0] B = 24'h070845;
  localparam logic [23:0] DV = 24'h995907;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{h:7'd12,  m:7'd34, s:7'd56,  blz:1'b0, dp:6'b000000, exp:24'h123456, blank0:1'b0};
    vecs[1] = '{h:7'd5,   m:7'd0,  s:7'd0,   blz:1'b1, dp:6'b010100, exp:24'h050000, blank0:1'b1};
    vecs[2] = '{h:7'd5,   m:7'd0,  s:7'd0,   blz:1'b0, dp:6'b000001, exp:24'h050000, blank0:1'b0};
    vecs[3] = '{h:7'd23,  m:7'd99, s:7'd127, blz:1'b0, dp:6'b100000, exp:24'h2399FF, blank0:1'b0};
    vecs[4] = '{h:7'd0,   m:7'd0,  s:7'd100, blz:1'b1, dp:6'b111111, exp:24'h0000FF, blank0:1'b1};
    vecs[5] = '{h:7'd127, m:7'd45, s:7'd9,   blz:1'b1, dp:6'b000000, exp:24'hFF4509, blank0:1'b0};
    vecs[6] = '{h:7'd0,   m:7'd7,  s:7'd0,   blz:1'b1, dp:6'b001010, exp:24'h000700, blank0:1'b1};
    vecs[7] = '{h:7'd10,  m:7'd59, s:7'd59,  blz:1'b1, dp:6'b110000, exp:24'h105959, blank0:1'b0};

    i_reset_n  = 1'b0;
    i_en       = 1'b1;
    i_load     = 1'b0;
    i_fields   = '0;
    i_dp       = 6'b101100;
    i_blank_lz = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    n = 0;
    sc = 0;

    // Reset state (cycle 0).
    chk("rst_busy",  o_busy, 1'b0);
    chk("rst_bcd",   o_bcd, 4'd0);
    chk("rst_sel",   o_digit_sel, 6'b000001);
    chk("rst_dp",    o_dp, 1'b1);
    chk("rst_blank_lz", o_blank, 1'b1);
    i_blank_lz = 1'b0;
    #1;
    chk("rst_blank", o_blank, 1'b0);

    // Load A in cycle 0: SHIFT 1..21, WAIT, commit at the edge ending cycle 23.
    i_fields = pack(7'd12, 7'd34, 7'd56);
    i_load = 1'b1;
    tick();
    i_load = 1'b0;
    while (n < 30) begin
      scan_chk(n < 24, (n < 24) ? 24'h0 : A);
      tick();
    end

    // Mid-frame load of B at cycle 30; a spurious load at cycle 40 is ignored.
    scan_chk(1'b0, A);
    i_fields = pack(7'd7, 7'd8, 7'd45);
    i_load = 1'b1;
    tick();
    i_load = 1'b0;
    while (n < 96) begin
      scan_chk(n < 72, (n < 72) ? A : B);
      i_load   = (n == 40);
      i_fields = (n == 40) ? pack(7'd99, 7'd99, 7'd99) : pack(7'd7, 7'd8, 7'd45);
      tick();
    end
    i_load = 1'b0;

    // Reset during SHIFT: everything returns to reset values immediately.
    i_fields = pack(7'd99, 7'd59, 7'd7);
    i_load = 1'b1;
    tick();
    i_load = 1'b0;
    tick();
    tick();
    chk("pre_abort_busy", o_busy, 1'b1);
    i_reset_n = 1'b0;
    #1;
    chk("abort_busy", o_busy, 1'b0);
    chk("abort_sel",  o_digit_sel, 6'b000001);
    chk("abort_bcd",  o_bcd, 4'd0);
    @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    n = 0;
    sc = 0;

    // Load sampled at the edge ending cycle 2: SHIFT 3..23 ends on the boundary,
    // so the commit waits for the boundary at cycle 47. Display stays zero.
    while (n < 2) begin
      scan_chk(1'b0, 24'h0);
      tick();
    end
    scan_chk(1'b0, 24'h0);
    i_load = 1'b1;
    tick();
    i_load = 1'b0;
    while (n < 62) begin
      scan_chk(n < 48, (n < 48) ? 24'h0 : DV);
      tick();
    end

    // Freeze scanning for 10 cycles at dwell 2 of index 3.
    i_en = 1'b0;
    #1;
    repeat (10) begin
      chk("frz_sel",   o_digit_sel, 6'b000000);
      chk("frz_blank", o_blank, 1'b1);
      chk("frz_bcd",   o_bcd, dig(DV, 3));
      tick();
    end
    i_en = 1'b1;
    #1;
    repeat (20) begin
      scan_chk(1'b0, DV);
      tick();
    end

    // Table-driven conversions.
    for (int v = 0; v < 8; v++) begin
      int cnt;
      i_fields   = pack(vecs[v].h, vecs[v].m, vecs[v].s);
      i_blank_lz = vecs[v].blz;
      i_dp       = vecs[v].dp;
      i_load     = 1'b1;
      tick();
      i_load = 1'b0;
      chk("vec_busy_rise", o_busy, 1'b1);
      cnt = 0;
      while (o_busy && cnt < 80) begin
        tick();
        cnt++;
      end
      chk("vec_busy_fall", o_busy, 1'b0);
      for (int d = 0; d < 6; d++) begin
        chk("vec_sel",   o_digit_sel, 6'(1) << d);
        chk("vec_bcd",   o_bcd, dig(vecs[v].exp, d));
        chk("vec_blank", o_blank, (d == 0) ? vecs[v].blank0 : 1'b0);
        chk("vec_dp",    o_dp, vecs[v].dp[5-d]);
        repeat (4) tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_digit_scanner.md
# bcd_digit_scanner

Sequential, parametrised successor to the combinational time-to-BCD digit mux. The block snapshots NUM_FIELDS binary fields (e.g. hours/minutes/seconds), converts each to two BCD digits with a one-bit-per-cycle double-dabble engine, and double-buffers the results. It then time-multiplexes the digits, MSD first, onto a single BCD/decimal-point output with a one-hot digit select. It sits between the clock counters and the 7-segment decoder/driver.

## Interface
- NUM_FIELDS, 3, number of binary fields; digit count D = 2*NUM_FIELDS
- FIELD_WIDTH, 7, bits per field; legal range 4..7
- SCAN_DIV, 16, clock cycles each digit is displayed; legal range ≥2
- i_clk  in  1  system clock, all logic on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_en  in  1  scan enable; low freezes scanning and blanks the display
- i_load  in  1  single-cycle request to snapshot and convert i_fields
- i_fields  in  NUM_FIELDS*FIELD_WIDTH  field k at bits [k*FIELD_WIDTH +: FIELD_WIDTH]; field 0 is least significant (seconds)
- i_dp  in  D  decimal points; i_dp[D-1] belongs to digit index 0 (MSD), i_dp[0] to the LSD
- i_blank_lz  in  1  blank a leading zero in digit index 0
- o_busy  out  1  load accepted, new data not yet committed to the display
- o_bcd  out  4  BCD of the currently selected digit
- o_dp  out  1  decimal point of the currently selected digit
- o_blank  out  1  current digit is to be blanked
- o_digit_sel  out  D  one-hot select; bit k marks digit index k (index 0 = MSD)

## Operation
- Conversion FSM states: IDLE, SHIFT, WAIT.
  - IDLE: i_load=1 captures i_fields into the snapshot register and enters SHIFT. i_load is ignored outside IDLE; there is no queue.
  - SHIFT: processes fields from highest to lowest, FIELD_WIDTH cycles per field. Each cycle, add 3 to every BCD nibble that is ≥5, then shift in the next field bit, MSB first. After the last bit, the two nibbles go to the pending buffer slot. FSM enters WAIT after NUM_FIELDS*FIELD_WIDTH cycles.
  - WAIT: holds until the frame boundary. On that edge, the pending buffer is copied to the display buffer and the FSM returns to IDLE.
- Overflow: a field value ≥100 stores both of its digits as 4'hF.
- Scanner:
  - Dwell counter counts 0..SCAN_DIV-1.
  - At terminal count, the digit index advances 0→1→…→D-1→0.
  - Frame boundary is the cycle with dwell = SCAN_DIV-1 and index = D-1.
- Outputs are combinational from registered index and display buffer.
  - o_digit_sel = 1<<index when i_en=1, otherwise all zeros.
  - o_bcd = display digit[index].
  - o_dp = i_dp[D-1-index], live.
  - o_blank = 1 when i_en=0, or when (i_blank_lz and index=0 and digit=0).
- i_en=0 freezes the dwell counter and index. The conversion FSM keeps running, but WAIT cannot commit until scanning resumes and reaches the boundary.

## Timing
- Reset (asynchronous assert, synchronous-release usage):
  - FSM = IDLE, o_busy = 0, index = 0, dwell = 0.
  - Display and pending buffers all zero.
  - o_bcd = 0, o_digit_sel = 1 (if i_en), o_dp = i_dp[D-1], o_blank = i_blank_lz.
- Reset mid-conversion aborts it. The display shows zeros and no partial data is ever committed.
- o_busy rises the cycle after i_load is sampled in IDLE. It falls the cycle after the commit edge.
- Conversion latency is NUM_FIELDS*FIELD_WIDTH cycles, from the first SHIFT cycle to entering WAIT.
- Commit happens only at a frame boundary, so a frame never mixes old and new digits (no tearing).
- If SHIFT ends on the boundary cycle itself, the commit waits for the next boundary.
- New data appears on index 0 the cycle after the commit edge.

## Test plan
- Reset, N=3, W=7, SCAN_DIV=4, i_en=1 → o_busy=0, o_bcd=0, o_digit_sel=6'b000001; index advances every 4 cycles and wraps after 24 cycles.
- Load 12/34/56 → o_busy high, 21 SHIFT cycles then WAIT. After the next frame boundary the scan reads 1,2,3,4,5,6, each for 4 cycles, with o_digit_sel walking bit 0→5.
- Hours=5 with i_blank_lz=1 → digit 0 has o_bcd=0, o_blank=1; digit 1 shows 5. With i_blank_lz=0 → o_blank=0.
- Seconds=127, minutes=99 → digits 4,5 = 4'hF; digits 2,3 = 9,9. Also pulse i_load during busy: it is ignored and o_busy timing is unchanged.
- Load issued mid-frame → the frame in progress still shows the old digits in full. A new frame starts with new data only after the boundary, with no mixed frame.
- Assert i_reset_n low during SHIFT → all state and outputs return immediately to reset values. Toggle i_en low for 10 cycles → o_digit_sel=0, o_blank=1, index/dwell hold, and scanning resumes from the same point.
